// File: rtl/rnd_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : rnd_share_sched
// Purpose  : Round-robin scheduler that feeds one shared 32b->16b rounding
//            unit from NREQ requesters and returns tagged 16b results.
//            Optional macro ADJ_SAT_EN: saturate instead of wrap, adds out_sat.
// Revision : 1.0 - initial release
// ============================================================================
module rnd_share_sched #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          adj_in,
  input  logic [15:0]          adj_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_data,
  output logic [ID_W-1:0]      out_id
`ifdef ADJ_SAT_EN
  ,
  output logic                 out_sat
`endif
);

  localparam logic [ID_W-1:0] LAST_ID_RST = ID_W'(NREQ - 1);

  logic [31:0]     req_word [NREQ];

  logic            s1_vld_q,   s1_vld_d;
  logic [31:0]     adj_in_q,   adj_in_d;
  logic [ID_W-1:0] s1_id_q,    s1_id_d;
  logic [ID_W-1:0] last_id_q,  last_id_d;
  logic            out_vld_q,  out_vld_d;
  logic [15:0]     out_data_q, out_data_d;
  logic [ID_W-1:0] out_id_q,   out_id_d;
  logic            out_sat_q,  out_sat_d;

  logic            stall;
  logic            s1_adv;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W:0]   cand;
  logic            grant;
  logic [15:0]     res_data;
  logic            res_sat;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_word[i] = req_data[32*i +: 32];
  end

  assign stall  = out_vld_q & ~out_ready;
  assign s1_adv = ~stall | ~s1_vld_q;

  // First valid requester at or after last_id+1, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_id_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NREQ)) begin
        cand = cand - (ID_W+1)'(NREQ);
      end
      if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign grant = s1_adv & gnt_found & ~rst;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

`ifdef ADJ_SAT_EN
  logic sat_ovf;
  assign sat_ovf  = (~(&adj_in_q[31:27]) & (|adj_in_q[31:27])) |
                    ((adj_in_q[27:12] == 16'h7FFF) & adj_in_q[11] & adj_in_q[10]);
  assign res_data = sat_ovf ? (adj_in_q[31] ? 16'h8000 : 16'h7FFF) : adj_out;
  assign res_sat  = sat_ovf;
`else
  assign res_data = adj_out;
  assign res_sat  = 1'b0;
`endif

  always_comb begin
    s1_vld_d   = s1_vld_q;
    adj_in_d   = adj_in_q;
    s1_id_d    = s1_id_q;
    last_id_d  = last_id_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    out_sat_d  = out_sat_q;

    // An empty S1 keeps filling even while S2 is stalled.
    if (s1_adv) begin
      s1_vld_d = gnt_found;
      if (gnt_found) begin
        adj_in_d  = req_word[gnt_idx];
        s1_id_d   = gnt_idx;
        last_id_d = gnt_idx;
      end
    end

    if (!stall) begin
      out_vld_d  = s1_vld_q;
      out_data_d = res_data;
      out_id_d   = s1_id_q;
      out_sat_d  = res_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      adj_in_q   <= '0;
      s1_id_q    <= '0;
      last_id_q  <= LAST_ID_RST;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_id_q   <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      adj_in_q   <= adj_in_d;
      s1_id_q    <= s1_id_d;
      last_id_q  <= last_id_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign adj_in    = adj_in_q;
  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
`ifdef ADJ_SAT_EN
  assign out_sat   = out_sat_q;
`else
  logic unused_sat;
  assign unused_sat = out_sat_q ^ res_sat;
`endif

endmodule
`default_nettype wire
